// File: rtl/rackctl_pkg.sv
// -----------------------------------------------------------------------------
// rackctl_pkg
// Shared definitions for the RACKCTL mode-0 link. The SURF responder and the
// TURFIO initiator both import this package, so the wire-format constants live
// here and nowhere else.
//   rackctl_state_e : responder state encoding
//   PREAMBLE        : last idle '1' followed by the 0,1,0,1 preamble, oldest first
//   ADDR_BITS       : width of the address/type word
//   DATA_BITS       : width of the write-data and read-data words
//   RD_BIT          : bit of the address word that marks a read (1) or write (0)
// -----------------------------------------------------------------------------
package rackctl_pkg;

  typedef enum logic [2:0] {
    ST_GUARD,
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_POST,
    ST_RDATA,
    ST_WAITACK
  } rackctl_state_e;

  localparam logic [4:0]  PREAMBLE  = 5'b10101;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned RD_BIT    = 23;

endpackage

// File: rtl/rackctl_shreg.sv
// -----------------------------------------------------------------------------
// rackctl_shreg
// 32-bit loadable MSB-first shift register with a bit counter. One instance is
// shared by the address, write-data and read-data phases of the responder.
//   sysclk_i  : clock
//   sysrst_i  : asynchronous active-high reset
//   load      : load load_data and clear the bit counter (wins over shift)
//   load_data : parallel load value
//   shift     : shift din in at the LSB, advancing the bit counter
//   din       : serial input bit
//   len       : number of bits in the current word
//   data      : register contents; data[31] is the serial output bit
//   done      : high during the shift that completes a len-bit word
// -----------------------------------------------------------------------------
module rackctl_shreg (
  input  logic        sysclk_i,
  input  logic        sysrst_i,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift,
  input  logic        din,
  input  logic [5:0]  len,
  output logic [31:0] data,
  output logic        done
);

  logic [5:0] cnt;

  assign done = shift && (cnt == len - 6'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk_i or posedge sysrst_i) begin
    if (sysrst_i) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= '0;
    end else if (shift) begin
      data <= {data[30:0], din};
      // Wrap at the word boundary so back-to-back words need no reload.
      cnt  <= done ? 6'd0 : cnt + 6'd1;
    end
  end

endmodule

// File: rtl/surf_rackctl_resp.sv
// -----------------------------------------------------------------------------
// surf_rackctl_resp
// SURF-side RACKCTL mode-0 responder. Deserializes a TURFIO request (preamble,
// 24-bit address/type word, optional 32-bit write word), issues it on the local
// register bus, then turns the line around: postamble '1', a start '0' once the
// bus has acked, and 32 read-data bits on reads. Line in/out/oe are registered
// in IOBs outside this block, so out/oe are decoded directly from state.
//   sysclk_i      : 125 MHz system clock
//   sysrst_i      : asynchronous active-high reset
//   en_i          : enables preamble search in IDLE
//   rackctl_in_i  : registered line sample
//   rackctl_out_o : value driven on the line
//   rackctl_oe_o  : 1 = drive, 0 = tristate
//   txn_valid_o   : bus request, held until txn_ack_i
//   txn_wr_o      : 1 = write
//   txn_addr_o    : register address
//   txn_wdata_o   : write data
//   txn_ack_i     : single-cycle bus completion
//   txn_rdata_i   : read data, valid with txn_ack_i
//   err_o         : one-cycle pulse when a response is abandoned at the deadline
// -----------------------------------------------------------------------------
module surf_rackctl_resp #(
  parameter int unsigned TURN_WAIT     = 64,
  parameter int unsigned START_MIN     = 136,
  parameter int unsigned RESP_DEADLINE = 240,
  parameter int unsigned GUARD         = 192
) (
  input  logic        sysclk_i,
  input  logic        sysrst_i,
  input  logic        en_i,
  input  logic        rackctl_in_i,
  output logic        rackctl_out_o,
  output logic        rackctl_oe_o,
  output logic        txn_valid_o,
  output logic        txn_wr_o,
  output logic [22:0] txn_addr_o,
  output logic [31:0] txn_wdata_o,
  input  logic        txn_ack_i,
  input  logic [31:0] txn_rdata_i,
  output logic        err_o
);

  import rackctl_pkg::*;

  if (!(TURN_WAIT > 0 && TURN_WAIT < START_MIN && START_MIN < RESP_DEADLINE &&
        RESP_DEADLINE < 256 && GUARD > 0 && GUARD <= 256)) begin : g_param_check
    $error("surf_rackctl_resp: need 0 < TURN_WAIT < START_MIN < RESP_DEADLINE < 256");
  end

  localparam logic [7:0] TURN_LAST  = 8'(TURN_WAIT - 1);
  localparam logic [7:0] START_T    = 8'(START_MIN);
  localparam logic [7:0] DEADLINE_T = 8'(RESP_DEADLINE);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD - 1);

  rackctl_state_e state, state_nxt;

  logic [4:0]           hist;
  logic [4:0]           hist_nxt;
  logic [7:0]           cnt;        // guard count in GUARD, turnaround t elsewhere
  logic                 cnt_clr;
  logic                 ack_flag;
  logic [31:0]          rdata_q;
  logic                 ack_now;
  logic                 ack_seen;
  logic                 issue;
  logic [ADDR_BITS-1:0] word_nxt;

  logic                 sh_load;
  logic [31:0]          sh_load_data;
  logic                 sh_shift;
  logic [5:0]           sh_len;
  logic [31:0]          sh_data;
  logic                 sh_done;

  rackctl_shreg u_shreg (
    .sysclk_i  (sysclk_i),
    .sysrst_i  (sysrst_i),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .din       (rackctl_in_i),
    .len       (sh_len),
    .data      (sh_data),
    .done      (sh_done)
  );

  // Compare against the history including the current sample, so the cycle
  // after the last preamble bit is already address bit 23.
  assign hist_nxt = {hist[3:0], rackctl_in_i};
  assign word_nxt = {sh_data[ADDR_BITS-2:0], rackctl_in_i};
  assign ack_now  = txn_valid_o && txn_ack_i;
  assign ack_seen = ack_flag || ack_now;

  // The turnaround counter must keep running across TURN -> POST, so it is
  // only cleared on entry to GUARD, IDLE or TURN (i.e. when the request issues).
  assign cnt_clr = (state_nxt != state) &&
                   (state_nxt == ST_GUARD || state_nxt == ST_IDLE || state_nxt == ST_TURN);

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt     = state;
    rackctl_oe_o  = 1'b0;
    rackctl_out_o = 1'b1;
    err_o         = 1'b0;
    issue         = 1'b0;
    sh_load       = 1'b0;
    sh_load_data  = '0;
    sh_shift      = 1'b0;
    sh_len        = 6'(ADDR_BITS);
    unique case (state)
      ST_GUARD: if (cnt == GUARD_LAST) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (en_i && hist_nxt == PREAMBLE) begin
          state_nxt = ST_ADDR;
          sh_load   = 1'b1;
        end
      end
      ST_ADDR: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          if (word_nxt[RD_BIT]) begin
            issue     = 1'b1;
            state_nxt = ST_TURN;
          end else begin
            state_nxt = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        sh_shift = 1'b1;
        sh_len   = 6'(DATA_BITS);
        if (sh_done) begin
          issue     = 1'b1;
          state_nxt = ST_TURN;
        end
      end
      ST_TURN: if (cnt == TURN_LAST) state_nxt = ST_POST;
      ST_POST: begin
        rackctl_oe_o = 1'b1;
        if (ack_seen && cnt >= START_T) begin
          rackctl_out_o = 1'b0;
          if (txn_wr_o) begin
            state_nxt = ST_GUARD;
          end else begin
            state_nxt    = ST_RDATA;
            sh_load      = 1'b1;
            sh_load_data = ack_flag ? rdata_q : txn_rdata_i;
          end
        end else if (cnt >= DEADLINE_T) begin
          rackctl_oe_o = 1'b0;
          err_o        = 1'b1;
          state_nxt    = ST_WAITACK;
        end
      end
      ST_RDATA: begin
        rackctl_oe_o  = 1'b1;
        rackctl_out_o = sh_data[31];
        sh_shift      = 1'b1;
        sh_len        = 6'(DATA_BITS);
        if (sh_done) state_nxt = ST_GUARD;
      end
      ST_WAITACK: if (ack_now) state_nxt = ST_GUARD;
      default: state_nxt = ST_GUARD;
    endcase
  end

  always_ff @(posedge sysclk_i or posedge sysrst_i) begin
    if (sysrst_i) begin
      state       <= ST_GUARD;
      hist        <= '0;
      cnt         <= '0;
      ack_flag    <= 1'b0;
      rdata_q     <= '0;
      txn_valid_o <= 1'b0;
      txn_wr_o    <= 1'b0;
      txn_addr_o  <= '0;
      txn_wdata_o <= '0;
    end else begin
      state <= state_nxt;
      // Cleared outside IDLE so a stale preamble cannot match on re-entry.
      hist  <= (state == ST_IDLE) ? hist_nxt : '0;

      if (cnt_clr)           cnt <= '0;
      else if (cnt != 8'hFF) cnt <= cnt + 8'd1;

      if (state == ST_ADDR && sh_done) begin
        txn_wr_o   <= ~word_nxt[RD_BIT];
        txn_addr_o <= word_nxt[RD_BIT-1:0];
      end
      if (state == ST_WDATA && sh_done) txn_wdata_o <= {sh_data[DATA_BITS-2:0], rackctl_in_i};

      if (issue)        txn_valid_o <= 1'b1;
      else if (ack_now) txn_valid_o <= 1'b0;

      if (issue) begin
        ack_flag <= 1'b0;
      end else if (ack_now) begin
        ack_flag <= 1'b1;
        rdata_q  <= txn_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_surf_rackctl_resp.sv
// -----------------------------------------------------------------------------
// tb_surf_rackctl_resp
// Drives RACKCTL frames as the TURFIO would and plays the register bus.
// Expected bus requests are queued when a frame is sent and checked by an
// independent monitor when txn_valid_o rises; line behaviour during the
// response is checked cycle by cycle against the turnaround timing.
// -----------------------------------------------------------------------------
module tb_surf_rackctl_resp;

  localparam int START_MIN     = 136;
  localparam int RESP_DEADLINE = 240;
  localparam int TURN_WAIT     = 64;

  logic        sysclk_i     = 1'b0;
  logic        sysrst_i     = 1'b1;
  logic        en_i         = 1'b0;
  logic        rackctl_in_i = 1'b1;
  logic        txn_ack_i    = 1'b0;
  logic [31:0] txn_rdata_i  = '0;
  logic        rackctl_out_o;
  logic        rackctl_oe_o;
  logic        txn_valid_o;
  logic        txn_wr_o;
  logic [22:0] txn_addr_o;
  logic [31:0] txn_wdata_o;
  logic        err_o;

  typedef struct {
    bit          wr;
    logic [22:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic valid_q = 1'b0;

  surf_rackctl_resp dut (
    .sysclk_i      (sysclk_i),
    .sysrst_i      (sysrst_i),
    .en_i          (en_i),
    .rackctl_in_i  (rackctl_in_i),
    .rackctl_out_o (rackctl_out_o),
    .rackctl_oe_o  (rackctl_oe_o),
    .txn_valid_o   (txn_valid_o),
    .txn_wr_o      (txn_wr_o),
    .txn_addr_o    (txn_addr_o),
    .txn_wdata_o   (txn_wdata_o),
    .txn_ack_i     (txn_ack_i),
    .txn_rdata_i   (txn_rdata_i),
    .err_o         (err_o)
  );

  always #4 sysclk_i = ~sysclk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One line bit per cycle, changed mid-cycle so the DUT samples it cleanly.
  task automatic drive(input logic line);
    @(negedge sysclk_i);
    rackctl_in_i = line;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1);
      #1;
      check("idle_oe", rackctl_oe_o, 1'b0);
    end
  endtask

  task automatic send_frame(input logic en, input logic [23:0] word,
                            input logic [31:0] data, input bit expect_req);
    logic [5:0] pre;
    req_t       r;
    pre  = 6'b110101;
    en_i = en;
    for (int i = 5; i >= 0; i--) drive(pre[i]);
    for (int i = 23; i >= 0; i--) drive(word[i]);
    if (!word[23]) for (int i = 31; i >= 0; i--) drive(data[i]);
    if (expect_req) begin
      r.wr    = !word[23];
      r.addr  = word[22:0];
      r.wdata = data;
      exp_q.push_back(r);
    end
  endtask

  // Cycle t=0 is the first cycle after the last frame bit. Ack is presented
  // for exactly cycle ack_t. rst_at >= 0 asserts reset in that cycle and returns.
  task automatic respond(input bit rd, input int ack_t, input logic [31:0] rdata, input int rst_at);
    int   start_t, end_t;
    bit   late;
    logic exp_oe, exp_out;
    late    = (ack_t > RESP_DEADLINE);
    start_t = (ack_t > START_MIN) ? ack_t : START_MIN;
    end_t   = late ? ack_t + 1 : (rd ? start_t + 33 : start_t + 1);
    for (int t = 0; t <= end_t; t++) begin
      @(negedge sysclk_i);
      rackctl_in_i = 1'b1;
      txn_ack_i    = (t == ack_t);
      txn_rdata_i  = (t == ack_t) ? rdata : 32'h0;
      if (t == rst_at) begin
        sysrst_i = 1'b1;
        #1;
        check("rst_oe", rackctl_oe_o, 1'b0);
        check("rst_valid", txn_valid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        txn_ack_i = 1'b0;
        return;
      end
      #1;
      exp_out = 1'b1;
      if (t < TURN_WAIT)               exp_oe = 1'b0;
      else if (late)                   exp_oe = (t < RESP_DEADLINE);
      else if (t <= start_t) begin
        exp_oe  = 1'b1;
        exp_out = (t != start_t);
      end else if (rd && t <= start_t + 32) begin
        exp_oe  = 1'b1;
        exp_out = rdata[31 - (t - start_t - 1)];
      end else                         exp_oe = 1'b0;
      check("resp_valid", txn_valid_o, (t <= ack_t));
      check("resp_err", err_o, (late && t == RESP_DEADLINE));
      check("resp_oe", rackctl_oe_o, exp_oe);
      if (exp_oe) check("resp_out", rackctl_out_o, exp_out);
    end
    txn_ack_i   = 1'b0;
    txn_rdata_i = 32'h0;
  endtask

  // Scoreboard monitor: every rising txn_valid_o must match the oldest frame.
  always @(negedge sysclk_i) begin : monitor
    req_t r;
    #2;
    if (txn_valid_o && !valid_q) begin
      check("req_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("req_wr", txn_wr_o, r.wr);
        check("req_addr", txn_addr_o, r.addr);
        if (r.wr) check("req_wdata", txn_wdata_o, r.wdata);
      end
    end
    valid_q = txn_valid_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sysclk_i);
    #1;
    check("reset_oe", rackctl_oe_o, 1'b0);
    check("reset_out", rackctl_out_o, 1'b1);
    check("reset_valid", txn_valid_o, 1'b0);
    check("reset_err", err_o, 1'b0);
    sysrst_i = 1'b0;
    idle(200);

    // Write, early ack.
    send_frame(1'b1, 24'h012345, 32'hDEADBEEF, 1'b1);
    respond(1'b0, 10, 32'h0, -1);
    idle(200);

    // Read, early ack.
    send_frame(1'b1, 24'h800010, 32'h0, 1'b1);
    respond(1'b1, 20, 32'hA5A5_0F0F, -1);
    idle(200);

    // Read, ack after START_MIN: start bit in the ack cycle.
    send_frame(1'b1, 24'h800123, 32'h0, 1'b1);
    respond(1'b1, 200, 32'h1234_5678, -1);
    idle(200);

    // Read, ack past the deadline: error pulse, valid held until ack.
    send_frame(1'b1, 24'h80ABCD, 32'h0, 1'b1);
    respond(1'b1, 241, 32'hFFFF_0000, -1);
    idle(200);

    // Payload full of 10101 patterns must not resync the block.
    send_frame(1'b1, 24'h002AAA, 32'h0001_5555, 1'b1);
    respond(1'b0, 30, 32'h0, -1);
    idle(200);

    // Reset during read-data bit 12; a frame inside the guard window is ignored.
    send_frame(1'b1, 24'h800042, 32'h0, 1'b1);
    respond(1'b1, 50, 32'hC3C3_3C3C, START_MIN + 1 + 12);
    repeat (2) @(negedge sysclk_i);
    sysrst_i = 1'b0;
    idle(100);
    send_frame(1'b1, 24'h001111, 32'h2222_3333, 1'b0);
    #1;
    check("guard_ignored_valid", txn_valid_o, 1'b0);
    idle(40);
    send_frame(1'b1, 24'h004444, 32'h5555_6666, 1'b1);
    respond(1'b0, 5, 32'h0, -1);
    idle(200);

    // en_i low gates the request; the next frame with en_i high is taken.
    send_frame(1'b0, 24'h000777, 32'h0000_0001, 1'b0);
    idle(80);
    check("en_off_valid", txn_valid_o, 1'b0);
    send_frame(1'b1, 24'h000888, 32'h0000_0002, 1'b1);
    respond(1'b0, 7, 32'h0, -1);
    idle(10);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
